// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and widths for the data-memory port arbiter.
package dmem_port_arbiter_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned DMEM_ADDR_W = 14;
  localparam int unsigned CNT_W       = 8;

  typedef enum logic {
    CPU_OWN  = 1'b0,
    HOST_OWN = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dmem_port_arbiter_sat_counter.sv
// 8-bit up-counter with synchronous clear (priority) and saturation at all-ones.
module dmem_port_arbiter_sat_counter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data-memory port between the MEM stage and the host,
// bounding host wait via a starvation counter and CPU stall via a burst limit.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = DMEM_ADDR_W,
  parameter int unsigned MAX_WAIT   = 4,
  parameter int unsigned HOST_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state_q;
  arb_state_e        state_d;
  logic              host_rvalid_q;
  logic              host_rvalid_d;
  logic [DATA_W-1:0] host_rdata_q;
  logic [DATA_W-1:0] host_rdata_d;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  burst_cnt;
  logic              host_win;
  logic              wait_inc;

  // Grant decision: host wins when the CPU is idle or its wait/burst bound says so.
  always_comb begin
    host_win      = 1'b0;
    state_d       = state_q;
    host_rvalid_d = 1'b0;
    host_rdata_d  = host_rdata_q;
    case (state_q)
      CPU_OWN:  host_win = host_req && (!cpu_req || (wait_cnt == CNT_W'(MAX_WAIT - 1)));
      HOST_OWN: host_win = host_req && (!cpu_req || (burst_cnt < CNT_W'(HOST_BURST)));
      default:  host_win = 1'b0;
    endcase
    state_d = host_win ? HOST_OWN : CPU_OWN;
    if (host_win && !host_we) begin
      host_rvalid_d = 1'b1;
      host_rdata_d  = mem_rdata;
    end
  end

  // A host denied while the CPU is served accumulates wait; anything else clears it.
  assign wait_inc = host_req & cpu_req & ~host_win;

  dmem_port_arbiter_sat_counter #(.W(CNT_W)) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (wait_inc),
    .clr_i (~wait_inc),
    .cnt_o (wait_cnt)
  );

  // Burst count is zero whenever the CPU owns the port, so the first host grant lands on 1.
  dmem_port_arbiter_sat_counter #(.W(CNT_W)) u_burst_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (host_win),
    .clr_i (~host_win),
    .cnt_o (burst_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= CPU_OWN;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  // Reset forces the grant and write strobe low immediately, not just at the next edge.
  assign host_gnt    = host_win & ~reset;
  assign cpu_stall   = cpu_req & host_gnt;
  assign mem_we      = ~reset & (host_gnt ? host_we : (cpu_req & cpu_we));
  assign mem_addr    = host_gnt ? host_addr  : cpu_addr;
  assign mem_wdata   = host_gnt ? host_wdata : cpu_wdata;
  assign cpu_rdata   = mem_rdata;
  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-ported data memory between two requesters: the pipeline MEM stage (CPU port) and an external host port used by the UVM environment for preload, peek and poke.
- Sits between the EXE/MEM register outputs and data_memory.
- Grants one access per cycle and stalls the pipeline while the host owns the memory.
- A starvation counter and a burst limit bound the waiting time on both sides.

Parameters:
- ADDR_W, 14, byte address width driven to data memory
- MAX_WAIT, 4, cycles a pending host request may wait before it is forced in ahead of the CPU (1..255)
- HOST_BURST, 4, maximum consecutive host grants before one cycle is returned to a requesting CPU (1..255)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  MEM stage wants the memory this cycle (load or store)
- cpu_we  in  1  CPU store
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  32  CPU store data
- cpu_rdata  out  32  combinational read data to MEM/WB
- cpu_stall  out  1  freeze F/D/E/M stages; OR-ed into the hazard-unit stalls
- host_req  in  1  host access pending; held high until host_gnt
- host_we  in  1  host write
- host_addr  in  ADDR_W  host address
- host_wdata  in  32  host write data
- host_gnt  out  1  host access performed this cycle
- host_rvalid  out  1  one-cycle pulse, host read data valid
- host_rdata  out  32  registered host read data
- mem_we  out  1  to data_memory w_enable
- mem_addr  out  ADDR_W  to data_memory addr
- mem_wdata  out  32  to data_memory w_data
- mem_rdata  in  32  from data_memory r_data (combinational read)

Behaviour:
- Reset values: state=CPU_OWN, wait_cnt=0, burst_cnt=0, host_gnt=0, host_rvalid=0, host_rdata=0, cpu_stall=0, mem_we=0.
- Reset mid-operation aborts any pending host transaction. No host_rvalid is issued for it, and the host must re-request.
- FSM state CPU_OWN:
  - If host_req and (!cpu_req or wait_cnt==MAX_WAIT-1), grant the host this cycle and go to HOST_OWN. burst_cnt becomes 1 and wait_cnt clears.
  - Else if host_req && cpu_req, the CPU is served and wait_cnt increments (saturating).
  - Else wait_cnt clears.
- FSM state HOST_OWN:
  - If host_req and (!cpu_req or burst_cnt<HOST_BURST), grant the host again and increment burst_cnt (saturating).
  - Otherwise return to CPU_OWN with burst_cnt=0. In that same cycle a CPU request is served if present, else the memory is idle.
- Grant decision (host_gnt, cpu_stall) is combinational from state, counters and current requests. Counters and state update at the posedge.
- Mux rules:
  - Host granted: mem_* = host_*, mem_we=host_we.
  - Else: mem_* = cpu_*, mem_we=cpu_req&cpu_we.
  - cpu_rdata = mem_rdata always. The pipeline ignores it while stalled.
- cpu_stall = cpu_req & host_gnt. The pipeline holds its MEM access and repeats it next cycle; the arbiter needs no CPU-side buffering.
- Host read, latency 1: in a grant cycle with !host_we, host_rdata <= mem_rdata at the posedge and host_rvalid pulses high the following cycle. Host writes produce no rvalid.
- Back-to-back host reads give rvalid every cycle; host_rdata updates each pulse.
- Simultaneous CPU store and host write to the same address resolve by grant order. The later grant's data persists, with no merging.
- With host_req never asserted the block is transparent: zero added latency and cpu_stall=0.
- Worst-case waits:
  - Host waits at most MAX_WAIT-1 cycles after assertion.
  - CPU stalls at most HOST_BURST consecutive cycles.

Decomposition:
- Shared package: state enum (CPU_OWN, HOST_OWN) and the data width constant (32). ADDR_W default matches the data memory address width.
- Sub-module sat_counter (8-bit, inc/clr/saturate), instantiated twice for wait_cnt and burst_cnt.

Test Plan:
1. Idle CPU, host writes 0xDEADBEEF to 0x010, then reads 0x010 -> host_gnt on each request cycle with no wait; host_rvalid one cycle after the read grant; host_rdata=0xDEADBEEF; cpu_stall stays 0.
2. cpu_req held high continuously, host_req asserted at cycle T, MAX_WAIT=4 -> CPU served T..T+2; host granted at T+3; cpu_stall=1 only at T+3.
3. Both requesting continuously, HOST_BURST=4, MAX_WAIT=4 -> repeating pattern of 3 CPU cycles then 4 host cycles; cpu_stall never exceeds 4 consecutive cycles.
4. CPU store of 0x11111111 to 0x020 and host write of 0x22222222 to 0x020 contending; host forced in after the CPU -> a later host read of 0x020 returns 0x22222222.
5. Reset asserted during host grant of a read -> host_rvalid stays 0 and all outputs return to reset values immediately; after reset, cpu_req alone is served with cpu_stall=0.
6. host_req held 0 for the whole run, random CPU loads and stores -> mem_* equals cpu_* every cycle; cpu_stall=0 and host_gnt=0 throughout.
